// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmit frame controller.
// Optional build macro: UART_TX_TWO_STOP_EN (second stop bit, STOP2 state).
package uart_tx_pkg;

  localparam int unsigned STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  // Binary state codes; width is 3 bits whether or not STOP2 is built.
  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;
  localparam state_t STOP2  = 3'd5;

  // Line levels on TX_OUT.
  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity of a data word; par_typ_i = 1 selects odd parity.
module parity_calc #(
  parameter int unsigned Data_Width = 8
) (
  input  logic [Data_Width-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  par_bit_o
);

  // XOR-reduce the word, then invert for odd parity.
  assign par_bit_o = (^data_i) ^ par_typ_i;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start, data, parity and stop
// bits onto a registered TX_OUT and enables the external serializer.
// Optional build macro: UART_TX_TWO_STOP_EN adds a second stop bit (STOP2).
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned Data_Width = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [Data_Width-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  Ser_data,
  input  logic                  Ser_done,
  output logic                  Ser_EN,
  output logic                  Busy,
  output logic                  TX_OUT
);

  state_t state_q, state_d;
  logic   par_bit_c;
  logic   par_bit_q;
  logic   par_en_q;
  logic   tx_q, tx_d;
  logic   accept;

  // Busy and Ser_EN come straight from the state register.
  assign Busy   = (state_q != IDLE);
  assign Ser_EN = (state_q == DATA);
  assign TX_OUT = tx_q;
  assign accept = Data_Valid & ~Busy;

  parity_calc #(
    .Data_Width (Data_Width)
  ) u_parity_calc (
    .data_i    (P_DATA),
    .par_typ_i (PAR_TYP),
    .par_bit_o (par_bit_c)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Parity bit and parity enable are frozen at accept for the whole frame.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
    end else if (accept) begin
      par_bit_q <= par_bit_c;
      par_en_q  <= PAR_EN;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = START;
      START:  state_d = DATA;
      DATA:   if (Ser_done) state_d = par_en_q ? PARITY : STOP;
      PARITY: state_d = STOP;
`ifdef UART_TX_TWO_STOP_EN
      STOP:   state_d = STOP2;
      STOP2:  state_d = IDLE;
`else
      STOP:   state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Line level for the bit belonging to the current state.
  always_comb begin
    tx_d = IDLE_LVL;
    case (state_q)
      IDLE:   tx_d = IDLE_LVL;
      START:  tx_d = START_LVL;
      DATA:   tx_d = Ser_data;
      PARITY: tx_d = par_bit_q;
      STOP:   tx_d = IDLE_LVL;
`ifdef UART_TX_TWO_STOP_EN
      STOP2:  tx_d = IDLE_LVL;
`endif
      default: tx_d = IDLE_LVL;
    endcase
  end

  // Output register; the line returns high on reset, even mid-frame.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      tx_q <= IDLE_LVL;
    end else begin
      tx_q <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with an LSB-first serializer model.
// Honours UART_TX_TWO_STOP_EN for the expected frame length.
module tb_uart_tx_ctrl;

  localparam int unsigned DW = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int XSTOP = 1;
`else
  localparam int XSTOP = 0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          Ser_data;
  logic          Ser_done;
  logic          Ser_EN;
  logic          Busy;
  logic          TX_OUT;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_ctrl #(.Data_Width(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Ser_data   (Ser_data),
    .Ser_done   (Ser_done),
    .Ser_EN     (Ser_EN),
    .Busy       (Busy),
    .TX_OUT     (TX_OUT)
  );

  always #5 CLK = ~CLK;

  // Serializer model: loads on accept, shifts LSB first while enabled.
  logic [DW-1:0] ser_sh;
  int            ser_cnt;
  always @(posedge CLK) begin
    if (!RST) begin
      ser_sh  <= '0;
      ser_cnt <= 0;
    end else if (Data_Valid && !Busy) begin
      ser_sh  <= P_DATA;
      ser_cnt <= 0;
    end else if (Ser_EN) begin
      ser_sh  <= ser_sh >> 1;
      ser_cnt <= ser_cnt + 1;
    end
  end
  assign Ser_data = ser_sh[0];
  assign Ser_done = (ser_cnt == DW - 1);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a word and step through the accept edge, then disturb the inputs.
  task automatic start_frame(input logic [DW-1:0] data, input logic pen,
                             input logic ptyp, input logic hold);
    P_DATA     = data;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_Valid = 1'b1;
    tick();
    P_DATA  = data ^ 8'h01;
    PAR_EN  = ~pen;
    PAR_TYP = ~ptyp;
    if (!hold) Data_Valid = 1'b0;
  endtask

  // Full frame: seq[0] is the first bit seen on TX_OUT after the accept.
  task automatic run_frame(input string tag, input logic [DW-1:0] data,
                           input logic pen, input logic ptyp, input logic hold,
                           input logic [0:15] seq, input int len);
    int busy_cnt = 0;
    int sen_cnt  = 0;
    start_frame(data, pen, ptyp, hold);
    for (int i = 0; i < len; i++) begin
      busy_cnt += int'(Busy);
      sen_cnt  += int'(Ser_EN);
      tick();
      check_eq($sformatf("%s_bit%0d", tag, i), 32'(TX_OUT), 32'(seq[i]));
    end
    check_eq({tag, "_busy_end"}, 32'(Busy), 32'd0);
    check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(len));
    check_eq({tag, "_ser_en_cycles"}, 32'(sen_cnt), 32'(DW));
  endtask

  initial begin
    RST        = 1'b0;
    P_DATA     = '0;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    // Power-up reset.
    tick(); tick(); tick();
    check_eq("rst_tx", 32'(TX_OUT), 32'd1);
    check_eq("rst_busy", 32'(Busy), 32'd0);
    check_eq("rst_ser_en", 32'(Ser_EN), 32'd0);
    RST = 1'b1;
    tick();
    check_eq("idle_busy", 32'(Busy), 32'd0);

    // Reset held three edges during DATA.
    start_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    check_eq("pre_rst_ser_en", 32'(Ser_EN), 32'd1);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("drst%0d_tx", i), 32'(TX_OUT), 32'd1);
      check_eq($sformatf("drst%0d_busy", i), 32'(Busy), 32'd0);
      check_eq($sformatf("drst%0d_ser_en", i), 32'(Ser_EN), 32'd0);
    end
    RST = 1'b1;
    tick();
    check_eq("post_rst_busy", 32'(Busy), 32'd0);

    // Even parity, odd parity, no parity, all ones.
    run_frame("even_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 16'b0_10100101_0_1_11111, 11 + XSTOP);
    tick();
    run_frame("odd_a5",  8'hA5, 1'b1, 1'b1, 1'b0, 16'b0_10100101_1_1_11111, 11 + XSTOP);
    tick();
    run_frame("nopar_00", 8'h00, 1'b0, 1'b0, 1'b0, 16'b0_00000000_1_111111, 10 + XSTOP);
    tick();
    run_frame("nopar_ff", 8'hFF, 1'b0, 1'b0, 1'b0, 16'b0_11111111_1_111111, 10 + XSTOP);
    tick();

    // Data_Valid held high: one accept per frame, one IDLE cycle between frames.
    run_frame("hold_3c", 8'h3C, 1'b1, 1'b0, 1'b1, 16'b0_00111100_0_1_11111, 11 + XSTOP);
    run_frame("hold_c3", 8'hC3, 1'b1, 1'b0, 1'b0, 16'b0_11000011_0_1_11111, 11 + XSTOP);
    tick();

    // Reset in PARITY aborts the frame.
    start_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    check_eq("par_state_busy", 32'(Busy), 32'd1);
    check_eq("par_state_tx_d7", 32'(TX_OUT), 32'd0);
    RST = 1'b0;
    tick();
    check_eq("prst_tx", 32'(TX_OUT), 32'd1);
    check_eq("prst_busy", 32'(Busy), 32'd0);
    check_eq("prst_ser_en", 32'(Ser_EN), 32'd0);
    RST = 1'b1;
    tick();
    run_frame("fresh_5a", 8'h5A, 1'b1, 1'b0, 1'b0, 16'b0_01011010_0_1_11111, 11 + XSTOP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
